game_flow_ctl: RTL and testbench

Top-level game sequencer for the Labyrinth tilt-maze. It consumes the ball's won_the_game and hit_a_hole flags plus a debounced start button, and decides when the ball runs, when it restarts and how many lives remain. It also generates the score-digit blink used after a win. It sits between the Ball, high_score and seven-segment logic in Nexys4fpga, and replaces the free-running blink counter there.

---
 rtl/game_flow_ctl_if.sv | 23 ++
 rtl/game_flow_ctl.sv | 170 +++++++++++++++++
 tb/tb_game_flow_ctl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/game_flow_ctl_if.sv
// Signal bundle between the game sequencer (master) and the Ball / display side (slave).
// The master samples the start button and ball flags, and drives run control, blink and status.
interface game_flow_ctl_if;
  logic       start;
  logic       won_the_game;
  logic       hit_a_hole;
  logic       run_en;
  logic       ball_restart;
  logic       blank_digits;
  logic       game_over;
  logic [2:0] lives;
  logic [2:0] state_out;

  modport master (
    input  start, won_the_game, hit_a_hole,
    output run_en, ball_restart, blank_digits, game_over, lives, state_out
  );

  modport slave (
    output start, won_the_game, hit_a_hole,
    input  run_en, ball_restart, blank_digits, game_over, lives, state_out
  );
endinterface

// File: rtl/game_flow_ctl.sv
// game_flow_ctl: Labyrinth sequencer (lives, restart pulse, win blink); GAME_CTL_PENALTY_EN builds the hole-penalty freeze.
// Latency: every output registered, 1 clk after the deciding input; no backpressure, inputs are levels sampled each cycle.
module game_flow_ctl #(
  parameter int BLINK_HALF     = 50000000,
  parameter int PENALTY_CYCLES = 100000000,
  parameter int MAX_LIVES      = 3
) (
  input  logic          clk,
  input  logic          reset,
  game_flow_ctl_if.master gif
);

  localparam int CNT_MAX = (BLINK_HALF > PENALTY_CYCLES) ? BLINK_HALF : PENALTY_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] BLINK_TC = CW'(BLINK_HALF - 1);
  localparam logic [2:0]    LIVES_INIT = 3'(MAX_LIVES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PLAY    = 3'd1,
    PENALTY = 3'd2,
    WIN     = 3'd3,
    OVER    = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    lives_q, lives_d;
  logic          run_en_q, run_en_d;
  logic          restart_q, restart_d;
  logic          blank_q, blank_d;
  logic          over_q, over_d;
  logic          start_q;
  logic          start_rise;
  logic          hole;

  assign start_rise = gif.start & ~start_q;

`ifdef GAME_CTL_PENALTY_EN
  localparam logic [CW-1:0] PEN_TC = CW'(PENALTY_CYCLES - 1);
  assign hole = gif.hit_a_hole;
`else
  // Ball stays in the hole for a couple of cycles after the restart; ignore it then.
  logic [1:0] mask_q, mask_d;
  assign hole = gif.hit_a_hole & (mask_q == 2'd0);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lives_d   = lives_q;
    restart_d = 1'b0;
    blank_d   = blank_q;
`ifndef GAME_CTL_PENALTY_EN
    mask_d    = (mask_q != 2'd0) ? mask_q - 2'd1 : 2'd0;
`endif
    case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d   = PLAY;
          lives_d   = LIVES_INIT;
          restart_d = 1'b1;
          cnt_d     = '0;
          blank_d   = 1'b0;
        end
      end
      PLAY: begin
        if (gif.won_the_game) begin
          state_d = WIN;
          cnt_d   = '0;
          blank_d = 1'b0;
        end else if (hole) begin
          if (lives_q > 3'd1) begin
            lives_d = lives_q - 3'd1;
`ifdef GAME_CTL_PENALTY_EN
            state_d = PENALTY;
            cnt_d   = '0;
`else
            restart_d = 1'b1;
            mask_d    = 2'd2;
`endif
          end else begin
            state_d = OVER;
            lives_d = 3'd0;
            cnt_d   = '0;
          end
        end
      end
`ifdef GAME_CTL_PENALTY_EN
      PENALTY: begin
        if (cnt_q == PEN_TC) begin
          state_d   = PLAY;
          restart_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      WIN: begin
        if (start_rise) begin
          state_d   = PLAY;
          lives_d   = LIVES_INIT;
          restart_d = 1'b1;
          blank_d   = 1'b0;
          cnt_d     = '0;
        end else if (cnt_q == BLINK_TC) begin
          blank_d = ~blank_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      OVER: begin
        blank_d = 1'b0;
        if (start_rise) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        blank_d = 1'b0;
      end
    endcase
    run_en_d = (state_d == PLAY);
    over_d   = (state_d == OVER);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lives_q   <= LIVES_INIT;
      run_en_q  <= 1'b0;
      restart_q <= 1'b0;
      blank_q   <= 1'b0;
      over_q    <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lives_q   <= lives_d;
      run_en_q  <= run_en_d;
      restart_q <= restart_d;
      blank_q   <= blank_d;
      over_q    <= over_d;
      start_q   <= gif.start;
    end
  end

`ifndef GAME_CTL_PENALTY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q <= 2'd0;
    end else begin
      mask_q <= mask_d;
    end
  end
`endif

  assign gif.run_en       = run_en_q;
  assign gif.ball_restart = restart_q;
  assign gif.blank_digits = blank_q;
  assign gif.game_over    = over_q;
  assign gif.lives        = lives_q;
  assign gif.state_out    = state_q;

endmodule

// File: tb/tb_game_flow_ctl.sv
// Directed-vector bench for game_flow_ctl with BLINK_HALF=4, PENALTY_CYCLES=8, MAX_LIVES=3.
// Penalty scenarios follow GAME_CTL_PENALTY_EN; without it the immediate-restart behaviour is exercised.
module tb_game_flow_ctl;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  game_flow_ctl_if gif ();

  game_flow_ctl #(
    .BLINK_HALF    (4),
    .PENALTY_CYCLES(8),
    .MAX_LIVES     (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .gif  (gif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_state"}, gif.state_out, 0);
    check({tag, "_run"}, gif.run_en, 0);
    check({tag, "_restart"}, gif.ball_restart, 0);
    check({tag, "_blank"}, gif.blank_digits, 0);
    check({tag, "_over"}, gif.game_over, 0);
    check({tag, "_lives"}, gif.lives, 3);
  endtask

  task automatic press_start();
    gif.start = 1'b1;
    step();
    gif.start = 1'b0;
  endtask

  task automatic one_hole();
    gif.hit_a_hole = 1'b1;
    step();
    gif.hit_a_hole = 1'b0;
  endtask

`ifdef GAME_CTL_PENALTY_EN
  task automatic penalty_round(input int unsigned exp_lives);
    one_hole();
    check("pen_state", gif.state_out, 2);
    check("pen_lives", gif.lives, exp_lives);
    repeat (7) step();
    check("pen_run_end", gif.run_en, 0);
    step();
    check("pen_ret_restart", gif.ball_restart, 1);
    check("pen_ret_state", gif.state_out, 1);
    check("pen_ret_lives", gif.lives, exp_lives);
    step();
    check("pen_ret_restart_off", gif.ball_restart, 0);
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    gif.start = 1'b0;
    gif.won_the_game = 1'b0;
    gif.hit_a_hole = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_reset_vals("rst");
    step();
    step();
    reset = 1'b1;
    step();
    check("idle_state", gif.state_out, 0);

    // Game start
    press_start();
    check("start_state", gif.state_out, 1);
    check("start_restart", gif.ball_restart, 1);
    check("start_run", gif.run_en, 1);
    check("start_lives", gif.lives, 3);
    step();
    check("start_restart_off", gif.ball_restart, 0);

`ifdef GAME_CTL_PENALTY_EN
    // Hole held across the penalty: ignored while frozen
    gif.hit_a_hole = 1'b1;
    step();
    check("hold_state", gif.state_out, 2);
    check("hold_lives", gif.lives, 2);
    check("hold_run", gif.run_en, 0);
    for (int i = 1; i <= 7; i++) begin
      step();
      check("hold_run_frozen", gif.run_en, 0);
      check("hold_restart_off", gif.ball_restart, 0);
      if (i == 4) begin
        check("hold_lives_mid", gif.lives, 2);
        gif.hit_a_hole = 1'b0;
      end
    end
    step();
    check("hold_ret_restart", gif.ball_restart, 1);
    check("hold_ret_state", gif.state_out, 1);
    check("hold_ret_run", gif.run_en, 1);
    check("hold_ret_lives", gif.lives, 2);
    step();
    check("hold_ret_restart_off", gif.ball_restart, 0);
    penalty_round(1);
`else
    // Hole held two cycles: one life lost, immediate restart
    gif.hit_a_hole = 1'b1;
    step();
    check("np_state", gif.state_out, 1);
    check("np_lives", gif.lives, 2);
    check("np_restart", gif.ball_restart, 1);
    check("np_run", gif.run_en, 1);
    step();
    gif.hit_a_hole = 1'b0;
    check("np_masked_lives", gif.lives, 2);
    check("np_restart_off", gif.ball_restart, 0);
    step();
    check("np_lives_hold", gif.lives, 2);
    one_hole();
    check("np2_lives", gif.lives, 1);
    check("np2_restart", gif.ball_restart, 1);
    step();
    step();
`endif

    // Last life gone
    one_hole();
    check("over_state", gif.state_out, 4);
    check("over_lives", gif.lives, 0);
    check("over_flag", gif.game_over, 1);
    check("over_run", gif.run_en, 0);
    step();
    check("over_hold", gif.game_over, 1);
    press_start();
    check("over_idle_state", gif.state_out, 0);
    check("over_idle_flag", gif.game_over, 0);
    check("over_idle_restart", gif.ball_restart, 0);
    step();
    press_start();
    check("replay_state", gif.state_out, 1);
    check("replay_lives", gif.lives, 3);
    check("replay_restart", gif.ball_restart, 1);
    step();

    // Win and hole together: win wins, then blink 0000111100001...
    gif.won_the_game = 1'b1;
    gif.hit_a_hole = 1'b1;
    step();
    gif.won_the_game = 1'b0;
    gif.hit_a_hole = 1'b0;
    check("win_state", gif.state_out, 3);
    check("win_lives", gif.lives, 3);
    check("win_run", gif.run_en, 0);
    check("win_blank0", gif.blank_digits, 0);
    for (int k = 1; k <= 11; k++) begin
      step();
      check("win_blink", gif.blank_digits, (k / 4) % 2);
    end
    step();
    check("win_blink_12", gif.blank_digits, 1);

    // Restart from WIN while digits are blank
    press_start();
    check("rewin_state", gif.state_out, 1);
    check("rewin_blank", gif.blank_digits, 0);
    check("rewin_restart", gif.ball_restart, 1);
    check("rewin_lives", gif.lives, 3);
    check("rewin_run", gif.run_en, 1);
    step();
    check("rewin_restart_off", gif.ball_restart, 0);

`ifdef GAME_CTL_PENALTY_EN
    // Asynchronous reset at penalty count 5
    one_hole();
    repeat (5) step();
    check("mid_state", gif.state_out, 2);
`else
    one_hole();
    check("mid_lives", gif.lives, 2);
    check("mid_restart", gif.ball_restart, 1);
    step();
`endif
    #2 reset = 1'b0;
    #1;
    check_reset_vals("arst");
    step();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check("post_rst_restart", gif.ball_restart, 0);
      check("post_rst_state", gif.state_out, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
